// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259A interrupt sequencer: handshake states,
// level count and the fixed-priority encoder used for both arbitration and EOI.
package pic_pkg;

    localparam int PIC_LEVELS       = 8;
    localparam int SPURIOUS_DEFAULT = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK1 = 2'd2,
        ST_ACK2 = 2'd3
    } pic_state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } prio_t;

    // Lowest set index wins (IR0 is the highest priority).
    function automatic prio_t highest_prio(input logic [PIC_LEVELS-1:0] vec);
        prio_t r;
        r.valid = 1'b0;
        r.idx   = 3'd0;
        for (int i = PIC_LEVELS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.valid = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [PIC_LEVELS-1:0] upto_mask(input logic [2:0] idx);
        logic [PIC_LEVELS-1:0] m;
        for (int i = 0; i < PIC_LEVELS; i++) begin
            m[i] = (3'(i) <= idx);
        end
        return m;
    endfunction

    function automatic logic [PIC_LEVELS-1:0] level_onehot(input logic [2:0] idx);
        return 8'h01 << idx;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Fully-nested priority resolution: picks the highest unmasked request and
// qualifies it against every in-service level of equal or higher priority.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic [7:0] isr,
    output logic       eligible,
    output logic [2:0] win
);

    logic [7:0] cand;
    prio_t      cand_p;

    // Masked ISR bits are deliberately not filtered: they still block lower levels.
    always_comb begin
        cand     = irr & ~imr;
        cand_p   = highest_prio(cand);
        win      = cand_p.idx;
        eligible = cand_p.valid && ((isr & upto_mask(cand_p.idx)) == 8'h00);
    end

endmodule

// File: rtl/pic_interrupt_sequencer.sv
// 8086-mode INTA sequencer for the 8259A model: IRR capture, priority-qualified
// INT, two-pulse acknowledge with vector drive, and normal/specific/automatic EOI.
module pic_interrupt_sequencer
    import pic_pkg::*;
#(
    parameter int EDGE_TRIG    = 0,
    parameter int SPURIOUS_LVL = SPURIOUS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir,
    input  logic [7:0] imr,
    input  logic       intaN,
    input  logic [4:0] vectorBase,
    input  logic       aeoi,
    input  logic       eoiStrobe,
    input  logic       eoiSpecific,
    input  logic [2:0] eoiLevel,
    output logic       intOut,
    output logic [7:0] irr,
    output logic [7:0] isr,
    output logic [7:0] vectorOut,
    output logic       vectorEn
);

    localparam logic [2:0] SPUR_LVL = 3'(SPURIOUS_LVL);

    pic_state_e state_q, state_d;
    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] ir_hist_q, ir_hist_d;
    logic [7:0] vec_q, vec_d;
    logic [2:0] lvl_q, lvl_d;
    logic       spur_q, spur_d;
    logic       int_q, int_d;
    logic       vec_en_q, vec_en_d;
    logic       inta_prev_q;

    logic       inta_fall;
    logic       inta_rise;
    logic       eligible;
    logic [2:0] win;
    logic       frozen;
    logic [7:0] isr_set;
    logic [7:0] isr_clr;
    logic [7:0] ack_clr;
    logic [7:0] ir_rise;
    prio_t      eoi_p;

    pic_priority_resolver u_resolver (
        .irr      (irr_q),
        .imr      (imr),
        .isr      (isr_q),
        .eligible (eligible),
        .win      (win)
    );

    assign inta_fall = inta_prev_q & ~intaN;
    assign inta_rise = ~inta_prev_q & intaN;

    always_comb begin
        state_d  = state_q;
        lvl_d    = lvl_q;
        spur_d   = spur_q;
        int_d    = int_q;
        vec_d    = vec_q;
        vec_en_d = vec_en_q;
        isr_set  = 8'h00;
        isr_clr  = 8'h00;
        ack_clr  = 8'h00;
        frozen   = (state_q == ST_ACK1) || (state_q == ST_ACK2);
        eoi_p    = highest_prio(isr_q);

        case (state_q)
            ST_IDLE: begin
                if (eligible) begin
                    state_d = ST_REQ;
                    int_d   = 1'b1;
                end
            end
            ST_REQ: begin
                // A request that vanished before INTA is answered with the spurious level.
                if (inta_fall) begin
                    frozen  = 1'b1;
                    int_d   = 1'b0;
                    state_d = ST_ACK1;
                    if (eligible) begin
                        lvl_d   = win;
                        spur_d  = 1'b0;
                        isr_set = level_onehot(win);
                        ack_clr = level_onehot(win);
                    end else begin
                        lvl_d  = SPUR_LVL;
                        spur_d = 1'b1;
                    end
                end
            end
            ST_ACK1: begin
                if (inta_rise) begin
                    state_d = ST_ACK2;
                end
            end
            ST_ACK2: begin
                if (inta_fall) begin
                    vec_d    = {vectorBase, lvl_q};
                    vec_en_d = 1'b1;
                end else if (inta_rise) begin
                    vec_en_d = 1'b0;
                    state_d  = ST_IDLE;
                    if (aeoi && !spur_q) begin
                        isr_clr = level_onehot(lvl_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (eoiStrobe) begin
            if (eoiSpecific) begin
                isr_clr = isr_clr | level_onehot(eoiLevel);
            end else if (eoi_p.valid) begin
                isr_clr = isr_clr | level_onehot(eoi_p.idx);
            end
        end

        // Clear before set so a same-cycle acknowledge of a level keeps it in service.
        isr_d = (isr_q & ~isr_clr) | isr_set;

        ir_rise   = ir & ~ir_hist_q;
        ir_hist_d = ir;
        if (EDGE_TRIG != 0) begin
            irr_d = frozen ? irr_q : (ir_rise | (irr_q & ir));
            irr_d = irr_d & ~ack_clr;
        end else begin
            irr_d = frozen ? irr_q : ir;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            irr_q       <= 8'h00;
            isr_q       <= 8'h00;
            ir_hist_q   <= 8'h00;
            vec_q       <= 8'h00;
            lvl_q       <= 3'd0;
            spur_q      <= 1'b0;
            int_q       <= 1'b0;
            vec_en_q    <= 1'b0;
            inta_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            ir_hist_q   <= ir_hist_d;
            vec_q       <= vec_d;
            lvl_q       <= lvl_d;
            spur_q      <= spur_d;
            int_q       <= int_d;
            vec_en_q    <= vec_en_d;
            inta_prev_q <= intaN;
        end
    end

    assign intOut    = int_q;
    assign irr       = irr_q;
    assign isr       = isr_q;
    assign vectorOut = vec_q;
    assign vectorEn  = vec_en_q;

endmodule

// File: tb/tb_pic_interrupt_sequencer.sv
// Directed bench for the interrupt sequencer: a level-triggered and an edge-triggered
// instance share stimulus; expected vectors are queued and matched as the bus is driven.
module tb_pic_interrupt_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ir;
    logic [7:0] imr;
    logic       intaN;
    logic [4:0] vectorBase;
    logic       aeoi;
    logic       eoiStrobe;
    logic       eoiSpecific;
    logic [2:0] eoiLevel;

    logic       l_int, e_int;
    logic [7:0] l_irr, e_irr, l_isr, e_isr, l_vec, e_vec;
    logic       l_ven, e_ven;

    logic       sel;
    logic       o_int, o_ven;
    logic [7:0] o_irr, o_isr, o_vec;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    logic       mon_prev = 1'b0;

    always #5 clk = ~clk;

    pic_interrupt_sequencer #(.EDGE_TRIG(0), .SPURIOUS_LVL(7)) dut_lvl (
        .clk(clk), .rst_n(rst_n), .ir(ir), .imr(imr), .intaN(intaN),
        .vectorBase(vectorBase), .aeoi(aeoi), .eoiStrobe(eoiStrobe),
        .eoiSpecific(eoiSpecific), .eoiLevel(eoiLevel),
        .intOut(l_int), .irr(l_irr), .isr(l_isr), .vectorOut(l_vec), .vectorEn(l_ven)
    );

    pic_interrupt_sequencer #(.EDGE_TRIG(1), .SPURIOUS_LVL(7)) dut_edge (
        .clk(clk), .rst_n(rst_n), .ir(ir), .imr(imr), .intaN(intaN),
        .vectorBase(vectorBase), .aeoi(aeoi), .eoiStrobe(eoiStrobe),
        .eoiSpecific(eoiSpecific), .eoiLevel(eoiLevel),
        .intOut(e_int), .irr(e_irr), .isr(e_isr), .vectorOut(e_vec), .vectorEn(e_ven)
    );

    assign o_int = sel ? e_int : l_int;
    assign o_ven = sel ? e_ven : l_ven;
    assign o_irr = sel ? e_irr : l_irr;
    assign o_isr = sel ? e_isr : l_isr;
    assign o_vec = sel ? e_vec : l_vec;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: every rising vectorEn consumes one queued expected vector.
    always @(negedge clk) begin
        if (o_ven && !mon_prev) begin
            if (exp_q.size() == 0) check("vec_unexpected", 32'(exp_q.size()), 32'd1);
            else                   check("vectorOut", o_vec, exp_q.pop_front());
        end
        mon_prev = o_ven;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ir = 8'h00; imr = 8'h00; intaN = 1'b1; aeoi = 1'b0;
        eoiStrobe = 1'b0; eoiSpecific = 1'b0; eoiLevel = 3'd0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic pulse1();
        intaN = 1'b0; cyc(2);
        intaN = 1'b1; cyc(2);
    endtask

    task automatic pulse2(input logic [7:0] expv);
        exp_q.push_back(expv);
        intaN = 1'b0; cyc(2);
        intaN = 1'b1; cyc(2);
    endtask

    task automatic eoi(input logic specific, input logic [2:0] lvl);
        eoiStrobe = 1'b1; eoiSpecific = specific; eoiLevel = lvl;
        cyc(1);
        eoiStrobe = 1'b0;
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        sel = 1'b0; vectorBase = 5'h08;
        rst_n = 1'b0; ir = 8'hFF; imr = 8'h00; intaN = 1'b1; aeoi = 1'b0;
        eoiStrobe = 1'b0; eoiSpecific = 1'b0; eoiLevel = 3'd0;
        cyc(2);
        check("rst_irr", o_irr, 8'h00);
        check("rst_isr", o_isr, 8'h00);
        check("rst_int", o_int, 1'b0);
        check("rst_vec", o_vec, 8'h00);
        check("rst_ven", o_ven, 1'b0);
        check("rst_edge_isr", e_isr, 8'h00);

        // Basic acknowledge on the edge instance
        sel = 1'b1; do_reset(); vectorBase = 5'h08;
        ir = 8'h08; cyc(3);
        check("basic_int", o_int, 1'b1);
        check("basic_irr", o_irr, 8'h08);
        pulse1();
        check("basic_isr1", o_isr, 8'h08);
        check("basic_irr_ack", o_irr, 8'h00);
        check("basic_int_drop", o_int, 1'b0);
        check("basic_ven_p1", o_ven, 1'b0);
        pulse2(8'h43);
        check("basic_int_after", o_int, 1'b0);
        check("basic_ven_after", o_ven, 1'b0);
        check("basic_isr_after", o_isr, 8'h08);
        check("basic_lvl_irr_frozen", l_irr, 8'h08);

        // Priority and nesting
        sel = 1'b0; do_reset(); vectorBase = 5'h10;
        ir = 8'h24; cyc(3);
        check("nest_int1", o_int, 1'b1);
        pulse1();
        check("nest_isr1", o_isr, 8'h04);
        pulse2(8'h82);
        check("nest_int_blocked", o_int, 1'b0);
        ir = 8'h26; cyc(3);
        check("nest_int2", o_int, 1'b1);
        pulse1();
        check("nest_isr2", o_isr, 8'h06);
        pulse2(8'h81);
        ir = 8'h20; cyc(2);
        check("nest_ir5_blocked", o_int, 1'b0);
        eoi(1'b0, 3'd0); cyc(1);
        check("nest_eoi1_isr", o_isr, 8'h04);
        check("nest_eoi1_int", o_int, 1'b0);
        eoi(1'b0, 3'd0); cyc(1);
        check("nest_eoi2_isr", o_isr, 8'h00);
        check("nest_eoi2_int", o_int, 1'b1);

        // Masking
        sel = 1'b0; do_reset(); vectorBase = 5'h04;
        imr = 8'h08; ir = 8'h08; cyc(4);
        check("mask_int_off", o_int, 1'b0);
        imr = 8'h00; cyc(1);
        check("mask_int_on", o_int, 1'b1);
        pulse1();
        pulse2(8'h23);
        check("mask_isr3", o_isr, 8'h08);
        do_reset(); vectorBase = 5'h04;
        ir = 8'h01; cyc(3);
        pulse1();
        pulse2(8'h20);
        check("mask_isr0", o_isr, 8'h01);
        ir = 8'h10; imr = 8'h11; cyc(4);
        check("mask_ir4_masked", o_int, 1'b0);
        imr = 8'h01; cyc(4);
        check("mask_isr0_blocks", o_int, 1'b0);
        eoi(1'b0, 3'd0); cyc(1);
        check("mask_eoi_isr", o_isr, 8'h00);
        check("mask_eoi_int", o_int, 1'b1);

        // Automatic EOI, then specific EOI in normal mode
        sel = 1'b0; do_reset(); vectorBase = 5'h12;
        aeoi = 1'b1; ir = 8'h40; cyc(3);
        check("aeoi_int", o_int, 1'b1);
        pulse1();
        check("aeoi_isr_set", o_isr, 8'h40);
        pulse2(8'h96);
        check("aeoi_isr_clr", o_isr, 8'h00);
        check("aeoi_reraise", o_int, 1'b1);
        aeoi = 1'b0;
        pulse1();
        pulse2(8'h96);
        check("seoi_isr6", o_isr, 8'h40);
        ir = 8'h48; cyc(3);
        check("seoi_int3", o_int, 1'b1);
        pulse1();
        pulse2(8'h93);
        check("seoi_isr_both", o_isr, 8'h48);
        eoi(1'b1, 3'd6);
        check("seoi_clear6", o_isr, 8'h08);

        // Spurious request
        sel = 1'b0; do_reset(); vectorBase = 5'h0A;
        ir = 8'h04; cyc(3);
        check("spur_int", o_int, 1'b1);
        ir = 8'h00; cyc(2);
        check("spur_irr_gone", o_irr, 8'h00);
        check("spur_int_held", o_int, 1'b1);
        pulse1();
        check("spur_isr_p1", o_isr, 8'h00);
        pulse2(8'h57);
        check("spur_isr_end", o_isr, 8'h00);
        check("spur_int_end", o_int, 1'b0);

        // Edge mode: held request acknowledged once; reset during ACK2
        sel = 1'b1; do_reset(); vectorBase = 5'h1F;
        ir = 8'h01; cyc(3);
        check("edge_int", o_int, 1'b1);
        pulse1();
        check("edge_isr", o_isr, 8'h01);
        check("edge_irr_ack", o_irr, 8'h00);
        pulse2(8'hF8);
        cyc(4);
        check("edge_once_int", o_int, 1'b0);
        check("edge_once_irr", o_irr, 8'h00);
        eoi(1'b0, 3'd0); cyc(3);
        check("edge_eoi_isr", o_isr, 8'h00);
        check("edge_no_new_edge", o_int, 1'b0);
        ir = 8'h00; cyc(1);
        ir = 8'h01; cyc(3);
        check("edge_retrig_int", o_int, 1'b1);
        pulse1();
        exp_q.push_back(8'hF8);
        intaN = 1'b0; cyc(1);
        check("edge_ack2_ven", o_ven, 1'b1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_ven", o_ven, 1'b0);
        check("rst_mid_irr", o_irr, 8'h00);
        check("rst_mid_isr", o_isr, 8'h00);
        check("rst_mid_int", o_int, 1'b0);
        intaN = 1'b1; cyc(2);
        rst_n = 1'b1; cyc(2);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pic_interrupt_sequencer.md
Name: pic_interrupt_sequencer

Overview:
- Sequences the 8086-mode INTA cycle for the 8259A model.
- Latches IR requests into IRR and gates them with the mask register value.
- Resolves fully-nested priority against ISR, raises INT, and runs the two-pulse INTA handshake that sets ISR and drives the vector onto the internal data bus.
- Handles non-specific, specific and automatic EOI. Sits between the mask register, the control logic and the data buffer.

Parameters:
- EDGE_TRIG, 0, 1 = edge-triggered IRR (rising edge of ir), 0 = level-triggered.
- SPURIOUS_LVL, 7, level reported when a request vanishes before the first INTA.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ir  in  8  interrupt request lines, already synchronous to clk.
- imr  in  8  mask; 1 = masked.
- intaN  in  1  CPU acknowledge, active low, synchronous, each pulse ≥1 cycle low.
- vectorBase  in  5  T7..T3 from ICW2.
- aeoi  in  1  automatic-EOI mode from ICW4.
- eoiStrobe  in  1  one-cycle OCW2 EOI command.
- eoiSpecific  in  1  1 = specific EOI, 0 = non-specific.
- eoiLevel  in  3  level for specific EOI.
- intOut  out  1  INT to CPU.
- irr  out  8  interrupt request register.
- isr  out  8  in-service register.
- vectorOut  out  8  vector byte {vectorBase, level}.
- vectorEn  out  1  vectorOut valid for the data buffer; the bus is high-Z while this is 0.

Behaviour:
- Reset (async, rst_n=0): irr=0, isr=0, intOut=0, vectorOut=0, vectorEn=0, state=IDLE, edge history=0.
- IRR, level mode: irr[i] follows ir[i] each cycle, except while frozen.
- IRR, edge mode: irr[i] set on a 0→1 of ir[i]; cleared when acknowledged, or when ir[i]=0 while not frozen.
- Freeze: IRR is frozen from the first INTA falling edge until the end of the second pulse.
- Priority: IR0 is highest.
  - cand = irr & ~imr.
  - win = lowest set index of cand.
  - Eligible only if isr has no bit at index ≤ win.
- Masking applies to candidates only; ISR bits of masked levels still block lower priorities.
- INTA edges: falling/rising edges of intaN are detected by registering intaN; each takes effect one cycle after the edge.
- State machine (IDLE, REQ, ACK1, ACK2):
  - IDLE: eligible → REQ, intOut=1 (registered, 1-cycle latency from irr).
  - REQ, intaN falling:
    - Latch lvl = win, set isr[lvl], clear irr[lvl] (edge mode), go to ACK1.
    - If no eligible request: lvl = SPURIOUS_LVL, no ISR change, spurious flag set.
    - intOut=0.
  - REQ, request disappears before INTA: intOut stays 1 (8259A behaviour); the spurious path covers it.
  - ACK1, intaN rising → ACK2. No bus drive during pulse 1.
  - ACK2, intaN falling: vectorOut = {vectorBase, lvl}, vectorEn=1 while intaN low.
  - ACK2, intaN rising:
    - vectorEn=0.
    - If aeoi and not spurious: clear isr[lvl].
    - Go to IDLE; INT may re-raise on the next cycle.
- EOI (eoiStrobe, any state):
  - Non-specific clears the lowest-index set isr bit.
  - Specific clears isr[eoiLevel].
  - No isr bits set: no-op.
- Same cycle as an ISR set: clear is applied first, then set, so set wins on the same bit.
- Reset mid-handshake: immediate return to IDLE, vectorEn=0 with no glitch beyond the reset assertion.

Decomposition:
- Shared package pic_pkg:
  - State enum.
  - SPURIOUS default.
  - PIC_LEVELS=8.
  - Function highest_prio(8-bit) → {valid, 3-bit index}; used for both win and non-specific EOI.
- One natural sub-module: pic_priority_resolver (combinational; irr, imr, isr → eligible, win).

Test Plan:
- Basic ack: imr=0x00, ir[3]=1, vectorBase=0x08 → intOut=1; INTA#1 → isr=0x08, irr[3]=0; INTA#2 → vectorOut=0x43, vectorEn=1; intOut=0 afterwards.
- Priority and nesting:
  - ir=0x24 → ack returns level 2, isr=0x04.
  - ir[1] rises → intOut=1, nested ack, isr=0x06.
  - ir[5] blocked until non-specific EOI twice → isr=0x00.
- Masking: imr=0x08, ir=0x08 → intOut stays 0.
  - imr→0x00 → intOut=1 next cycle.
  - With isr=0x01, a masked ir[4] never raises INT.
- AEOI: aeoi=1, ir[6] → after second INTA rising, isr=0x00; specific EOI level 6 in ISR mode clears only bit 6.
- Spurious: level mode, ir[2] pulses and drops before INTA#1 → no ISR set, vector {base,3'b111}, isr unchanged after EOI-free completion.
- Edge mode + reset: EDGE_TRIG=1, ir[0] held high → one ack only; assert rst_n=0 during ACK2 → vectorEn=0, irr=isr=0 immediately.
